// File: rtl/bht.sv
// ---------------------------------------------------------------------------
// bht -- gshare branch history table
//
// Predicts conditional-branch direction at fetch by indexing a table of 2-bit
// saturating counters with PC XOR a speculative global history register (GHR).
// Resolved outcomes from execute train the counters. On a mispredict, the GHR
// is rebuilt from the history snapshot that travelled with the branch.
//
// Ports:
//   clock       in   1          single clock, all state on the rising edge
//   reset       in   1          synchronous, active-high
//   ready       out  1          table initialised, requests accepted
//   get_valid   in   1          prediction request
//   get_pc      in   32         PC of the fetched branch
//   pred_valid  out  1          prediction valid (one cycle after request)
//   pred_taken  out  1          predicted direction
//   pred_ghr    out  GHR_WIDTH  GHR snapshot used for the index
//   upd_valid   in   1          resolved conditional branch
//   upd_pc      in   32         PC of the resolved branch
//   upd_ghr     in   GHR_WIDTH  pred_ghr that travelled with the branch
//   upd_pred    in   1          pred_taken that travelled with the branch
//   upd_branch  in   1          actual outcome
//   mispredict  out  1          registered pulse: upd_branch != upd_pred
//   fsm_state   out  1          debug view of the FSM (0 = INIT, 1 = RUN)
//
// Handshake: there is no back-pressure. A request (get_valid or upd_valid) is
// accepted in any cycle where ready is high, and is ignored while ready is
// low. An accepted prediction request produces pred_valid exactly one cycle
// later, unless a mispredict repair happens in the same cycle, in which case
// the request is dropped.
// ---------------------------------------------------------------------------
module bht #(
    parameter int BHT_DEPTH = 256,
    parameter int GHR_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 ready,
    input  logic                 get_valid,
    input  logic [31:0]          get_pc,
    output logic                 pred_valid,
    output logic                 pred_taken,
    output logic [GHR_WIDTH-1:0] pred_ghr,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic [GHR_WIDTH-1:0] upd_ghr,
    input  logic                 upd_pred,
    input  logic                 upd_branch,
    output logic                 mispredict,
    output logic                 fsm_state
);

    localparam int IDX = $clog2(BHT_DEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Counter storage; not reset, the INIT sweep rewrites every entry.
    logic [1:0]           cnt_q [BHT_DEPTH];

    state_e               state_q;
    logic [IDX-1:0]       init_cnt_q;
    logic [GHR_WIDTH-1:0] ghr_q;
    logic [GHR_WIDTH-1:0] ghr_d;
    logic                 ready_q;
    logic                 pred_valid_q;
    logic                 pred_taken_q;
    logic [GHR_WIDTH-1:0] pred_ghr_q;
    logic                 mispredict_q;

    logic [IDX-1:0]       get_idx;
    logic [IDX-1:0]       upd_idx;
    logic                 rd_taken;
    logic [1:0]           upd_cnt;
    logic [1:0]           upd_cnt_d;
    logic                 get_acc;
    logic                 upd_acc;
    logic                 mis_now;
    logic [GHR_WIDTH:0]   spec_shift;
    logic [GHR_WIDTH:0]   fix_shift;

    // PC bits outside the index field do not take part in the hash.
    logic                 unused_pc_bits;
    assign unused_pc_bits = ^{get_pc[31:IDX+2], get_pc[1:0],
                              upd_pc[31:IDX+2], upd_pc[1:0]};

    // Index hash: word-aligned PC bits XOR zero-extended history.
    assign get_idx  = get_pc[IDX+1:2] ^ IDX'(ghr_q);
    assign upd_idx  = upd_pc[IDX+1:2] ^ IDX'(upd_ghr);
    assign rd_taken = cnt_q[get_idx][1];
    assign upd_cnt  = cnt_q[upd_idx];

    assign get_acc  = get_valid & ready_q;
    assign upd_acc  = upd_valid & ready_q;
    assign mis_now  = upd_acc & (upd_branch != upd_pred);

    // Shifting through a GHR_WIDTH+1 wide vector and keeping the low bits
    // covers GHR_WIDTH == 1 without a special case.
    assign spec_shift = {ghr_q,   rd_taken};
    assign fix_shift  = {upd_ghr, upd_branch};

    always_comb begin
        upd_cnt_d = upd_cnt;
        if (upd_branch) begin
            if (upd_cnt != 2'b11) upd_cnt_d = upd_cnt + 2'b01;
        end else begin
            if (upd_cnt != 2'b00) upd_cnt_d = upd_cnt - 2'b01;
        end
    end

    // Repair on mispredict beats the speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (mis_now) begin
            ghr_d = fix_shift[GHR_WIDTH-1:0];
        end else if (get_acc) begin
            ghr_d = spec_shift[GHR_WIDTH-1:0];
        end
    end

    // Counter table writes: init sweep, then training.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == ST_INIT) begin
                cnt_q[init_cnt_q] <= 2'b01;
            end else if (upd_acc) begin
                cnt_q[upd_idx] <= upd_cnt_d;
            end
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_INIT;
            init_cnt_q   <= '0;
            ghr_q        <= '0;
            ready_q      <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_ghr_q   <= '0;
            mispredict_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_cnt_q   <= init_cnt_q + IDX'(1);
                    pred_valid_q <= 1'b0;
                    mispredict_q <= 1'b0;
                    if (init_cnt_q == IDX'(BHT_DEPTH - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    ghr_q        <= ghr_d;
                    pred_valid_q <= get_acc & ~mis_now;
                    mispredict_q <= mis_now;
                    if (get_acc && !mis_now) begin
                        pred_taken_q <= rd_taken;
                        pred_ghr_q   <= ghr_q;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign ready      = ready_q;
    assign pred_valid = pred_valid_q;
    assign pred_taken = pred_taken_q;
    assign pred_ghr   = pred_ghr_q;
    assign mispredict = mispredict_q;
    assign fsm_state  = state_q;

endmodule
